// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic-cycle master bridge.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    typedef struct packed {
        logic [WB_DATA_W-1:0] rdata;
        logic                 err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts BUS cycles without ack/err; flags expiry on the cycle that would reach
// TIMEOUT_CYCLES. Only instantiated when WB_MASTER_TIMEOUT_EN is defined.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int             CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     cnt_q <= '0;
        else if (clr_i)  cnt_q <= '0;
        else if (inc_i)  cnt_q <= cnt_q + 1'b1;
    end

    // Expire at the edge where the count would reach TIMEOUT_CYCLES, so the
    // strobe is high for exactly TIMEOUT_CYCLES cycles.
    assign expired_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Valid/ready request port to single Wishbone classic read/write cycles.
// Define WB_MASTER_TIMEOUT_EN to end hung cycles with an error response.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic                req_we_i,
    input  logic [DATA_W/8-1:0] req_sel_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic [ADDR_W-1:0]   adr_o,
    output logic                we_o,
    output logic [DATA_W/8-1:0] sel_o,
    output logic [DATA_W-1:0]   dat_o,
    input  logic [DATA_W-1:0]   dat_i,
    input  logic                ack_i,
    input  logic                err_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    wb_state_e state_q, state_d;
    logic      tmo;
    logic      bus_end, bus_err;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (state_q != BUS),
        .inc_i     (state_q == BUS && !ack_i && !err_i),
        .expired_o (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    assign bus_end     = ack_i | err_i | tmo;
    assign bus_err     = err_i | tmo;
    assign req_ready_o = (state_q == IDLE);
    assign stb_o       = cyc_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = BUS;
            BUS:     if (bus_end)     state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_o       <= 1'b0;
            adr_o       <= '0;
            we_o        <= 1'b0;
            sel_o       <= '0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    cyc_o <= 1'b1;
                    adr_o <= req_addr_i;
                    we_o  <= req_we_i;
                    sel_o <= req_sel_i;
                    dat_o <= req_wdata_i;
                end
                // err (or timeout) takes priority over a simultaneous ack
                BUS: if (bus_end) begin
                    cyc_o       <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= bus_err;
                    rsp_rdata_o <= (bus_err || we_o) ? '0 : dat_i;
                end
                RESP: if (rsp_ready_i) rsp_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized self-checking bench for wb_master_bridge (timeout checks follow
// WB_MASTER_TIMEOUT_EN).
module tb_wb_master_bridge;
    import wb_pkg::*;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [3:0]  req_sel_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    wb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
        .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // What the transaction should return, from the slave's outcome alone.
    function automatic wb_rsp_t exp_rsp(input logic we, input logic is_err, input logic [31:0] sdata);
        wb_rsp_t r;
        r.err   = is_err;
        r.rdata = (is_err || we) ? 32'h0 : sdata;
        return r;
    endfunction

    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd);
        chk("idle_ready", req_ready_o, 1);
        req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
        req_sel_i = sel; req_wdata_i = wd;
        tick();
        // scramble request inputs: bus fields must stay latched
        req_valid_i = 1'b0; req_addr_i = $urandom; req_we_i = ~we;
        req_sel_i = 4'($urandom); req_wdata_i = $urandom;
    endtask

    // mode: 0 ack, 1 err, 2 ack+err together
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                          input logic [31:0] wd, input int waits, input int mode,
                          input int rdy_delay, input logic [31:0] sdata);
        wb_rsp_t e;
        int stb_cnt;
        e = exp_rsp(we, mode != 0, sdata);
        issue(addr, we, sel, wd);
        stb_cnt = 0;
        while (cyc_o === 1'b1 && stb_cnt < 100) begin
            stb_cnt++;
            chk("bus_fields", {stb_o, we_o, sel_o, adr_o, dat_o}, {1'b1, we, sel, addr, wd});
            chk("ready_in_bus", req_ready_o, 0);
            if (stb_cnt > waits) begin
                ack_i = (mode != 1); err_i = (mode != 0); dat_i = sdata;
            end else begin
                ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
            end
            tick();
        end
        ack_i = 1'b0; err_i = 1'b0;
        chk("stb_cycles", stb_cnt, waits + 1);
        for (int i = 0; i <= rdy_delay; i++) begin
            chk("rsp_valid", rsp_valid_o, 1);
            chk("rsp_fields", {rsp_rdata_o, rsp_err_o}, e);
            chk("ready_in_resp", req_ready_o, 0);
            chk("cyc_in_resp", cyc_o, 0);
            rsp_ready_i = (i == rdy_delay);
            ack_i = 1'($urandom); err_i = 1'($urandom); dat_i = $urandom;
            tick();
        end
        ack_i = 1'b0; err_i = 1'b0; rsp_ready_i = 1'b0;
        chk("rsp_drop", rsp_valid_o, 0);
        chk("ready_back", req_ready_o, 1);
    endtask

    initial begin
        int cnt;
        // reset
        tick(); tick();
        chk("rst_bus", {cyc_o, stb_o, we_o, adr_o, sel_o, dat_o}, '0);
        chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, '0);
        chk("rst_ready", req_ready_o, 1);
        rst_ni = 1'b1;
        tick();

        do_txn(32'h20000c08, 1'b0, 4'hf, 32'h0, 0, 0, 0, 32'h0000_1234);
        do_txn(32'h20000c00, 1'b1, 4'b0011, 32'hAABB_CCDD, 0, 0, 0, 32'hDEAD_BEEF);
        do_txn(32'h20000c04, 1'b0, 4'hf, 32'h0, 3, 0, 5, 32'h5555_AAAA);
        do_txn(32'h20000c10, 1'b0, 4'hf, 32'h0, 1, 2, 1, 32'h1111_2222);
        do_txn(32'h20000c14, 1'b1, 4'hf, 32'h1, 2, 1, 0, 32'h3333_4444);

        for (int k = 0; k < 25; k++) begin
            int r;
            r = $urandom_range(0, 7);
            do_txn($urandom, 1'($urandom), 4'($urandom), $urandom,
                   $urandom_range(0, 5), (r == 0) ? 1 : (r == 1) ? 2 : 0,
                   $urandom_range(0, 3), $urandom);
        end

        // silent slave
        issue(32'h20000c20, 1'b0, 4'hf, 32'h0);
        cnt = 0;
`ifdef WB_MASTER_TIMEOUT_EN
        while (cyc_o === 1'b1 && cnt < 100) begin
            cnt++; ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
            tick();
        end
        chk("tmo_stb_cycles", cnt, TMO);
        for (int i = 0; i < 3; i++) begin
            chk("tmo_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b1, 32'h0});
            chk("tmo_cyc", cyc_o, 0);
            ack_i = 1'b1; dat_i = $urandom;
            tick();
        end
        ack_i = 1'b0; rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("tmo_ready_back", req_ready_o, 1);
`else
        while (cnt < 1000) begin
            cnt++; ack_i = 1'b0; err_i = 1'b0;
            tick();
        end
        chk("hang_cyc", {cyc_o, stb_o, rsp_valid_o}, 3'b110);
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        tick();
        chk("hang_cleared", {cyc_o, rsp_valid_o, req_ready_o}, 3'b001);
`endif

        // reset in the middle of a bus cycle
        issue(32'h20000c30, 1'b1, 4'hf, 32'hCAFE_F00D);
        tick();
        chk("mid_cyc_pre", cyc_o, 1);
        #2;
        rst_ni = 1'b0; ack_i = 1'b1;
        #1;
        chk("mid_rst_bus", {cyc_o, stb_o, we_o, adr_o, sel_o, dat_o}, '0);
        chk("mid_rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, '0);
        chk("mid_rst_ready", req_ready_o, 1);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ack_i = 1'b0;
            chk("post_rst_norsp", {rsp_valid_o, cyc_o, req_ready_o}, 3'b001);
        end

        do_txn(32'h20000c40, 1'b0, 4'hf, 32'h0, 0, 0, 0, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
